// File: rtl/simple_processor_pkg.sv
// Shared types and constants for simple_processor and its memory-side blocks,
// including the imem/dmem arbiter states and its default tuning constants.
package simple_processor_pkg;

    localparam int ADDR_WIDTH = 16;
    localparam int DATA_WIDTH = 16;

    localparam int ARB_MAX_DMEM_BURST = 4;
    localparam int ARB_TIMEOUT_CYCLES = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and data ports:
// dmem priority with a starvation guard for imem, and a per-transaction timeout.
module mem_arbiter #(
    parameter int ADDR_WIDTH     = simple_processor_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH     = simple_processor_pkg::DATA_WIDTH,
    parameter int MAX_DMEM_BURST = simple_processor_pkg::ARB_MAX_DMEM_BURST,
    parameter int TIMEOUT_CYCLES = simple_processor_pkg::ARB_TIMEOUT_CYCLES
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic                  imem_req_i,
    input  logic [ADDR_WIDTH-1:0] imem_addr_i,
    output logic [DATA_WIDTH-1:0] imem_rdata_o,
    output logic                  imem_ack_o,
    input  logic                  dmem_req_i,
    input  logic                  dmem_we_i,
    input  logic [ADDR_WIDTH-1:0] dmem_addr_i,
    input  logic [DATA_WIDTH-1:0] dmem_wdata_i,
    output logic [DATA_WIDTH-1:0] dmem_rdata_o,
    output logic                  dmem_ack_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_ack_i,
    output logic                  err_o,
    output logic                  busy_o
);
    import simple_processor_pkg::arb_state_t;
    import simple_processor_pkg::arb_owner_t;
    import simple_processor_pkg::IDLE;
    import simple_processor_pkg::IBUSY;
    import simple_processor_pkg::DBUSY;
    import simple_processor_pkg::RESP;
    import simple_processor_pkg::OWN_I;
    import simple_processor_pkg::OWN_D;

    localparam int BW = $clog2(MAX_DMEM_BURST + 1);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    arb_state_t    state;
    arb_owner_t    owner;
    logic [BW-1:0] burst_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          grant_d;
    logic          grant_i;
    logic          busy;
    logic          tmo_hit;
    logic          done;

    always_comb begin
        grant_d = 1'b0;
        grant_i = 1'b0;
        if (state == IDLE) begin
            grant_d = dmem_req_i && !((burst_cnt == BW'(MAX_DMEM_BURST)) && imem_req_i);
            grant_i = !grant_d && imem_req_i;
        end
    end

    assign busy    = (state == IBUSY) || (state == DBUSY);
    // A memory ack in the timeout cycle takes precedence over the timeout.
    assign tmo_hit = (TIMEOUT_CYCLES != 0) && busy && !mem_ack_i &&
                     (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign done    = busy && (mem_ack_i || tmo_hit);

    // Counts dmem grants taken while imem was waiting.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            burst_cnt <= '0;
        end else if (grant_i) begin
            burst_cnt <= '0;
        end else if (grant_d) begin
            if (!imem_req_i)
                burst_cnt <= '0;
            else if (burst_cnt != BW'(MAX_DMEM_BURST))
                burst_cnt <= burst_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i)
            tmo_cnt <= '0;
        else if (grant_d || grant_i)
            tmo_cnt <= '0;
        else if (busy && !mem_ack_i)
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state        <= IDLE;
            owner        <= OWN_I;
            mem_req_o    <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
            imem_rdata_o <= '0;
            imem_ack_o   <= 1'b0;
            dmem_rdata_o <= '0;
            dmem_ack_o   <= 1'b0;
            err_o        <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state       <= DBUSY;
                        owner       <= OWN_D;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= dmem_we_i;
                        mem_addr_o  <= dmem_addr_i;
                        mem_wdata_o <= dmem_wdata_i;
                        busy_o      <= 1'b1;
                    end else if (grant_i) begin
                        state       <= IBUSY;
                        owner       <= OWN_I;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= 1'b0;
                        mem_addr_o  <= imem_addr_i;
                        mem_wdata_o <= '0;
                        busy_o      <= 1'b1;
                    end
                end
                IBUSY, DBUSY: begin
                    if (done) begin
                        state     <= RESP;
                        mem_req_o <= 1'b0;
                        mem_we_o  <= 1'b0;
                        busy_o    <= 1'b0;
                        err_o     <= !mem_ack_i;
                        if (owner == OWN_D) begin
                            dmem_ack_o   <= 1'b1;
                            dmem_rdata_o <= mem_ack_i ? mem_rdata_i : '0;
                        end else begin
                            imem_ack_o   <= 1'b1;
                            imem_rdata_o <= mem_ack_i ? mem_rdata_i : '0;
                        end
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    imem_ack_o <= 1'b0;
                    dmem_ack_o <= 1'b0;
                    err_o      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
